// File: rtl/hazard_pipeline_controller_if.sv
// hazard_pipeline_controller_if: front-end hazard bus between fetch/hazard sources and the controller.
interface hazard_pipeline_controller_if #(
    parameter int FPU_CNT_W = 4,
    parameter int PERF_W    = 16
);
    logic [31:0]          i_if_pc;
    logic [31:0]          i_if_instr;
    logic                 i_load_use_stall;
    logic                 i_branch_taken;
    logic                 i_fpu_start;
    logic [FPU_CNT_W-1:0] i_fpu_cycles;
    logic                 o_pc_write_en;
    logic [31:0]          o_if_id_pc;
    logic [31:0]          o_if_id_instr;
    logic                 o_if_id_valid;
    logic                 o_id_ex_bubble;
    logic                 o_pipe_hold;
    logic [PERF_W-1:0]    o_stall_cycles;

    modport master (
        output i_if_pc, i_if_instr, i_load_use_stall, i_branch_taken, i_fpu_start, i_fpu_cycles,
        input  o_pc_write_en, o_if_id_pc, o_if_id_instr, o_if_id_valid, o_id_ex_bubble,
               o_pipe_hold, o_stall_cycles
    );

    modport slave (
        input  i_if_pc, i_if_instr, i_load_use_stall, i_branch_taken, i_fpu_start, i_fpu_cycles,
        output o_pc_write_en, o_if_id_pc, o_if_id_instr, o_if_id_valid, o_id_ex_bubble,
               o_pipe_hold, o_stall_cycles
    );
endinterface

// File: rtl/hazard_pipeline_controller.sv
// hazard_pipeline_controller: applies stall/flush/FPU-hold decisions to PC and the IF/ID register.
module hazard_pipeline_controller #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          FPU_CNT_W = 4,
    parameter int          PERF_W    = 16
) (
    input logic                          clk,
    input logic                          rst_n,
    hazard_pipeline_controller_if.slave  bus
);
    typedef enum logic {RUN, FPU_WAIT} state_t;

    state_t               r_state;
    logic [FPU_CNT_W-1:0] r_cnt;
    logic [31:0]          r_pc;
    logic [31:0]          r_instr;
    logic                 r_valid;
    logic [PERF_W-1:0]    r_stall;
    logic                 w_run;
    logic                 w_flush;
    logic                 w_fpu_go;
    logic                 w_stall;
    logic                 w_pc_we;

    // Branch beats an FPU issue, which in turn suppresses a load-use stall.
    always_comb begin
        w_run    = r_state == RUN;
        w_flush  = w_run && bus.i_branch_taken;
        w_fpu_go = w_run && !bus.i_branch_taken && bus.i_fpu_start && bus.i_fpu_cycles != '0;
        w_stall  = w_run && !bus.i_branch_taken && !w_fpu_go && bus.i_load_use_stall;
        w_pc_we  = w_run && !w_stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
            r_stall <= '0;
        end else begin
            if (!w_pc_we && r_stall != '1)
                r_stall <= r_stall + 1'b1;
            if (w_flush) begin
                r_pc    <= '0;
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end else if (w_pc_we) begin
                r_pc    <= bus.i_if_pc;
                r_instr <= bus.i_if_instr;
                r_valid <= 1'b1;
            end
            if (w_fpu_go) begin
                r_state <= FPU_WAIT;
                r_cnt   <= bus.i_fpu_cycles;
            end else if (!w_run) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == 1)
                    r_state <= RUN;
            end
        end
    end

    assign bus.o_pc_write_en  = w_pc_we;
    assign bus.o_id_ex_bubble = w_flush || w_stall;
    assign bus.o_pipe_hold    = !w_run;
    assign bus.o_if_id_pc     = r_pc;
    assign bus.o_if_id_instr  = r_instr;
    assign bus.o_if_id_valid  = r_valid;
    assign bus.o_stall_cycles = r_stall;
endmodule

// File: tb/tb_hazard_pipeline_controller.sv
// tb_hazard_pipeline_controller: scoreboard bench comparing the controller against a behavioural model.
module tb_hazard_pipeline_controller;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic        pc_we;
        logic        bubble;
        logic        hold;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [15:0] stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb[$];

    int          m_wait;
    int          m_cnt;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    int          m_stall;

    hazard_pipeline_controller_if #(.FPU_CNT_W(4), .PERF_W(16)) bus ();

    hazard_pipeline_controller #(.NOP_INSTR(NOP), .FPU_CNT_W(4), .PERF_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wait  = 0;
        m_cnt   = 0;
        m_pc    = 0;
        m_instr = NOP;
        m_valid = 0;
        m_stall = 0;
    endtask

    task automatic cyc(input logic rn, input logic [31:0] pc, input logic [31:0] ins,
                       input logic lus, input logic br, input logic fs, input logic [3:0] fc);
        exp_t e;
        exp_t g;
        bit   fgo;
        @(negedge clk);
        rst_n                = rn;
        bus.i_if_pc          = pc;
        bus.i_if_instr       = ins;
        bus.i_load_use_stall = lus;
        bus.i_branch_taken   = br;
        bus.i_fpu_start      = fs;
        bus.i_fpu_cycles     = fc;
        if (!rn) model_reset();
        fgo = 0;
        if (m_wait != 0) begin
            e.pc_we = 0; e.bubble = 0; e.hold = 1;
        end else if (br) begin
            e.pc_we = 1; e.bubble = 1; e.hold = 0;
        end else if (fs && fc != 0) begin
            e.pc_we = 1; e.bubble = 0; e.hold = 0; fgo = 1;
        end else if (lus) begin
            e.pc_we = 0; e.bubble = 1; e.hold = 0;
        end else begin
            e.pc_we = 1; e.bubble = 0; e.hold = 0;
        end
        e.pc = m_pc; e.instr = m_instr; e.valid = m_valid; e.stall = 16'(m_stall);
        sb.push_back(e);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk("pc_write_en", 32'(bus.o_pc_write_en), 32'(g.pc_we));
            chk("id_ex_bubble", 32'(bus.o_id_ex_bubble), 32'(g.bubble));
            chk("pipe_hold", 32'(bus.o_pipe_hold), 32'(g.hold));
            chk("if_id_pc", bus.o_if_id_pc, g.pc);
            chk("if_id_instr", bus.o_if_id_instr, g.instr);
            chk("if_id_valid", 32'(bus.o_if_id_valid), 32'(g.valid));
            chk("stall_cycles", 32'(bus.o_stall_cycles), 32'(g.stall));
        end
        if (rn) begin
            if (!e.pc_we && m_stall < 65535) m_stall++;
            if (m_wait == 0 && br) begin
                m_pc = 0; m_instr = NOP; m_valid = 0;
            end else if (e.pc_we) begin
                m_pc = pc; m_instr = ins; m_valid = 1;
            end
            if (fgo) begin
                m_wait = 1; m_cnt = fc;
            end else if (m_wait != 0) begin
                if (m_cnt == 1) m_wait = 0;
                m_cnt--;
            end
        end
    endtask

    initial begin
        model_reset();
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h0, 32'h00500093, 0, 0, 0, 0);
        cyc(1, 32'h4, 32'h0000A103, 0, 0, 0, 0);
        cyc(1, 32'h8, 32'h00208133, 1, 0, 0, 0);
        cyc(1, 32'h8, 32'h00208133, 0, 0, 0, 0);
        cyc(1, 32'hC, 32'h00310193, 1, 1, 0, 0);
        cyc(1, 32'h40, 32'h00100213, 0, 0, 0, 0);
        cyc(1, 32'h44, 32'h123452D3, 1, 0, 1, 4'd3);
        cyc(1, 32'h48, 32'h00000333, 1, 0, 0, 0);
        cyc(1, 32'h48, 32'h00000333, 0, 1, 1, 4'd2);
        cyc(1, 32'h48, 32'h00000333, 0, 0, 0, 0);
        cyc(1, 32'h48, 32'h00000333, 0, 0, 0, 0);
        cyc(1, 32'h4C, 32'h00100393, 1, 0, 1, 4'd0);
        cyc(1, 32'h4C, 32'h00100393, 0, 0, 1, 4'd0);
        cyc(1, 32'h50, 32'h00200413, 0, 0, 1, 4'd1);
        cyc(1, 32'h54, 32'h00300493, 0, 0, 0, 0);
        for (int i = 0; i < 200; i++)
            cyc(1, $urandom, $urandom, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 4)));
        while (m_stall < 65540 - 5 && m_stall < 65532)
            cyc(1, 32'h100, 32'h00000013, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            cyc(1, 32'h100, 32'h00000013, 1, 0, 0, 0);
        cyc(1, 32'h104, 32'h00500513, 0, 0, 0, 0);
        cyc(1, 32'h108, 32'h00600593, 0, 0, 1, 4'd5);
        cyc(1, 32'h10C, 32'h00700613, 0, 0, 0, 0);
        cyc(1, 32'h10C, 32'h00700613, 0, 0, 0, 0);
        cyc(0, 32'h10C, 32'h00700613, 0, 0, 0, 0);
        cyc(1, 32'h10C, 32'h00700613, 0, 0, 0, 0);
        cyc(1, 32'h110, 32'h00800693, 0, 0, 0, 0);
        cyc(1, 32'h114, 32'h00900713, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
